// File: rtl/aes_key_expand.sv
// Sequential AES-128 key schedule: one round key per rk_valid/rk_ready handshake,
// SubWord via four byte-substitution ROM instances.

module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Entry 0 sits in the top byte; {~din, 3'b000} is the LSB offset of entry din.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX[{~din, 3'b000} +: 8];
endmodule

module aes_key_expand #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    state_t       state_q, state_d;
    logic         load, advance, finish;
    logic [3:0]   next_round;
    logic [7:0]   rcon;
    logic [31:0]  rot_w3, sub_w, temp;
    logic [31:0]  n0, n1, n2, n3;
    logic         hs;

    assign busy       = (state_q == EMIT);
    assign rk_valid   = (state_q == EMIT);
    assign hs         = rk_valid && rk_ready;
    assign next_round = rk_round + 4'd1;

    always_comb begin
        rcon = 8'h00;
        case (next_round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign rot_w3 = {rk_out[23:0], rk_out[31:24]};

    aes_sbox u_sbox0 (.din(rot_w3[31:24]), .dout(sub_w[31:24]));
    aes_sbox u_sbox1 (.din(rot_w3[23:16]), .dout(sub_w[23:16]));
    aes_sbox u_sbox2 (.din(rot_w3[15:8]),  .dout(sub_w[15:8]));
    aes_sbox u_sbox3 (.din(rot_w3[7:0]),   .dout(sub_w[7:0]));

    assign temp = sub_w ^ {rcon, 24'h000000};
    assign n0   = rk_out[127:96] ^ temp;
    assign n1   = rk_out[95:64]  ^ n0;
    assign n2   = rk_out[63:32]  ^ n1;
    assign n3   = rk_out[31:0]   ^ n2;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (hs) begin
                    if (rk_round == LAST) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rk_out   <= '0;
            rk_round <= '0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= finish;
            if (load) begin
                rk_out   <= key_in;
                rk_round <= '0;
            end else if (advance) begin
                rk_out   <= {n0, n1, n2, n3};
                rk_round <= next_round;
            end else if (finish) begin
                rk_round <= '0;
            end
        end
    end
endmodule
